// File: rtl/arbitro_codificador_if.sv
// Handshake and status bundle between the arbiter/encoder and its neighbours.
// Error-injection inputs exist only when ARBITRO_ERR_INJ_EN is defined.
interface arbitro_codificador_if #(parameter int CNT_W = 8);
    logic             req0_valid;
    logic [3:0]       req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [3:0]       req1_data;
    logic             req1_ready;
    logic             cod_valid;
    logic [7:0]       cod_data;
    logic             cod_src;
    logic             cod_ready;
    logic             busy;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
`ifdef ARBITRO_ERR_INJ_EN
    logic             err_inj;
    logic [2:0]       err_inj_pos;
`endif

    modport master (
`ifdef ARBITRO_ERR_INJ_EN
        output err_inj, err_inj_pos,
`endif
        output req0_valid, req0_data, req1_valid, req1_data, cod_ready,
        input  req0_ready, req1_ready, cod_valid, cod_data, cod_src, busy, cnt0, cnt1
    );

    modport slave (
`ifdef ARBITRO_ERR_INJ_EN
        input  err_inj, err_inj_pos,
`endif
        input  req0_valid, req0_data, req1_valid, req1_data, cod_ready,
        output req0_ready, req1_ready, cod_valid, cod_data, cod_src, busy, cnt0, cnt1
    );
endinterface

// File: rtl/arbitro_codificador.sv
// Two-requester round-robin front end for a shared SECDED(8,4) encoder; optional ARBITRO_ERR_INJ_EN flips one codeword bit.
// Latency: accept at edge T, codeword valid after edge T+1; one word per 3 cycles at best.
// Backpressure: codeword held until cod_ready; requesters see ready=0 outside IDLE.

module module_codificador (
    input  logic [3:0] data,
    output logic [7:0] code
);
    logic p1, p2, p3;

    // Hamming positions 1..7 = p1 p2 d0 p3 d1 d2 d3, bit 7 is overall parity
    assign p1 = data[0] ^ data[1] ^ data[3];
    assign p2 = data[0] ^ data[2] ^ data[3];
    assign p3 = data[1] ^ data[2] ^ data[3];
    assign code[6:0] = {data[3], data[2], data[1], p3, data[0], p2, p1};
    assign code[7]   = ^code[6:0];
endmodule

module arbitro_codificador #(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arbitro_codificador_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, SEND = 2'd2} state_t;

    state_t     state, state_nxt;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic       src_q;
    logic [3:0] data_q;
    logic [7:0] code;
    logic [7:0] code_inj;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    module_codificador u_cod (.data(data_q), .code(code));

`ifdef ARBITRO_ERR_INJ_EN
    always_comb begin
        code_inj = code;
        if (bus.err_inj)
            code_inj[bus.err_inj_pos] = ~code[bus.err_inj_pos];
    end
`else
    assign code_inj = code;
`endif

    // Lone requester wins; on contention the one not served last time wins
    assign grant  = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    assign accept = bus.req0_ready | bus.req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
                    bus.req0_ready = ~grant;
                    bus.req1_ready = grant;
                    state_nxt      = ENC;
                end
            end
            ENC:     state_nxt = SEND;
            SEND:    if (bus.cod_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= 1'b1;
            data_q        <= 4'd0;
            src_q         <= 1'b0;
            bus.cod_valid <= 1'b0;
            bus.cod_data  <= 8'd0;
            bus.cod_src   <= 1'b0;
            bus.cnt0      <= '0;
            bus.cnt1      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q <= grant ? bus.req1_data : bus.req0_data;
                        src_q  <= grant;
                    end
                end
                ENC: begin
                    bus.cod_data  <= code_inj;
                    bus.cod_src   <= src_q;
                    bus.cod_valid <= 1'b1;
                end
                SEND: begin
                    if (bus.cod_ready) begin
                        bus.cod_valid <= 1'b0;
                        last_grant    <= bus.cod_src;
                        if (bus.cod_src) begin
                            if (bus.cnt1 != CNT_MAX) bus.cnt1 <= bus.cnt1 + CNT_ONE;
                        end else begin
                            if (bus.cnt0 != CNT_MAX) bus.cnt0 <= bus.cnt0 + CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_arbitro_codificador.sv
// Directed bench for arbitro_codificador: main instance CNT_W=8, second instance CNT_W=2 for saturation.
module tb_arbitro_codificador;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    arbitro_codificador_if #(.CNT_W(8)) ifa ();
    arbitro_codificador_if #(.CNT_W(2)) ifb ();

    arbitro_codificador #(.CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    arbitro_codificador #(.CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        ifa.req0_valid = 0; ifa.req0_data = 0; ifa.req1_valid = 0; ifa.req1_data = 0; ifa.cod_ready = 0;
        ifb.req0_valid = 0; ifb.req0_data = 0; ifb.req1_valid = 0; ifb.req1_data = 0; ifb.cod_ready = 0;
`ifdef ARBITRO_ERR_INJ_EN
        ifa.err_inj = 0; ifa.err_inj_pos = 0; ifb.err_inj = 0; ifb.err_inj_pos = 0;
`endif

        // Reset state, readys gated while in reset
        rst_n = 1'b0;
        tick;
        ifa.req0_valid = 1;
        ifa.req1_valid = 1;
        #1;
        chk("rst_cod_valid", ifa.cod_valid, 0);
        chk("rst_cod_data", ifa.cod_data, 8'h00);
        chk("rst_cod_src", ifa.cod_src, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_cnt0", ifa.cnt0, 0);
        chk("rst_cnt1", ifa.cnt1, 0);
        chk("rst_req0_ready", ifa.req0_ready, 0);
        chk("rst_req1_ready", ifa.req1_ready, 0);
        ifa.req0_valid = 0;
        ifa.req1_valid = 0;
        tick;
        rst_n = 1'b1;

        // Single word from requester 0: 1011 -> 0x55
        tick;
        ifa.cod_ready  = 1;
        #1;
        chk("idle_ready_ignored_cnt0", ifa.cnt0, 0);
        ifa.req0_valid = 1;
        ifa.req0_data  = 4'b1011;
        #1;
        chk("t1_req0_ready", ifa.req0_ready, 1);
        chk("t1_req1_ready", ifa.req1_ready, 0);
        tick;
        ifa.req0_valid = 0;
        #1;
        chk("t1_enc_busy", ifa.busy, 1);
        chk("t1_enc_ready", ifa.req0_ready, 0);
        chk("t1_enc_valid", ifa.cod_valid, 0);
        tick;
        chk("t1_send_valid", ifa.cod_valid, 1);
        chk("t1_send_data", ifa.cod_data, 8'h55);
        chk("t1_send_src", ifa.cod_src, 0);
        chk("t1_send_cnt0", ifa.cnt0, 0);
        tick;
        chk("t1_done_valid", ifa.cod_valid, 0);
        chk("t1_done_cnt0", ifa.cnt0, 1);
        chk("t1_done_busy", ifa.busy, 0);

        // Both requesters, alternating, accepts 3 cycles apart
        do_reset;
        ifa.cod_ready  = 1;
        ifa.req0_data  = 4'h0;
        ifa.req1_data  = 4'hF;
        ifa.req0_valid = 1;
        ifa.req1_valid = 1;
        #1;
        chk("t2_first_req0_ready", ifa.req0_ready, 1);
        chk("t2_first_req1_ready", ifa.req1_ready, 0);
        tick;
        tick;
        chk("t2_w0_data", ifa.cod_data, 8'h00);
        chk("t2_w0_src", ifa.cod_src, 0);
        chk("t2_w0_valid", ifa.cod_valid, 1);
        tick;
        chk("t2_second_req1_ready", ifa.req1_ready, 1);
        chk("t2_second_req0_ready", ifa.req0_ready, 0);
        tick;
        tick;
        chk("t2_w1_data", ifa.cod_data, 8'hFF);
        chk("t2_w1_src", ifa.cod_src, 1);
        tick;
        chk("t2_third_req0_ready", ifa.req0_ready, 1);
        tick;
        tick;
        chk("t2_w2_data", ifa.cod_data, 8'h00);
        chk("t2_w2_src", ifa.cod_src, 0);
        tick;
        ifa.req0_valid = 0;
        ifa.req1_valid = 0;
        #1;
        chk("t2_cnt0", ifa.cnt0, 2);
        chk("t2_cnt1", ifa.cnt1, 1);

        // Backpressure: 0001 -> 0x87 held for 5 cycles
        do_reset;
        ifa.cod_ready  = 0;
        ifa.req1_valid = 1;
        ifa.req1_data  = 4'b0001;
        #1;
        chk("t3_req1_ready", ifa.req1_ready, 1);
        tick;
        ifa.req1_valid = 0;
        tick;
        ifa.req0_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_valid", ifa.cod_valid, 1);
            chk("t3_hold_data", ifa.cod_data, 8'h87);
            chk("t3_hold_src", ifa.cod_src, 1);
            chk("t3_hold_req0_ready", ifa.req0_ready, 0);
            chk("t3_hold_cnt1", ifa.cnt1, 0);
            tick;
        end
        ifa.req0_valid = 0;
        ifa.cod_ready  = 1;
        tick;
        chk("t3_hs_cnt1", ifa.cnt1, 1);
        chk("t3_hs_valid", ifa.cod_valid, 0);

        // Saturating counter on the CNT_W=2 instance
        do_reset;
        ifb.cod_ready  = 1;
        ifb.req0_valid = 1;
        ifb.req0_data  = 4'h6;
        for (int i = 0; i < 5; i++) begin
            tick;
            tick;
            tick;
            chk("t4_sat_cnt0", ifb.cnt0, sat_exp[i]);
            chk("t4_sat_cnt1", ifb.cnt1, 0);
        end
        ifb.req0_valid = 0;

        // Reset while a word sits in ENC
        do_reset;
        ifa.cod_ready  = 1;
        ifa.req0_valid = 1;
        ifa.req0_data  = 4'h3;
        tick;
        tick;
        tick;
        chk("t5_pre_cnt0", ifa.cnt0, 1);
        tick;
        ifa.req0_valid = 0;
        chk("t5_in_enc_busy", ifa.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_busy", ifa.busy, 0);
        chk("t5_async_valid", ifa.cod_valid, 0);
        chk("t5_async_cnt0", ifa.cnt0, 0);
        tick;
        rst_n = 1'b1;
        ifa.req0_valid = 1;
        ifa.req1_valid = 1;
        #1;
        chk("t5_prio_req0_ready", ifa.req0_ready, 1);
        chk("t5_prio_req1_ready", ifa.req1_ready, 0);
        ifa.req0_valid = 0;
        ifa.req1_valid = 0;
        tick;
        chk("t5_no_present", ifa.cod_valid, 0);

`ifdef ARBITRO_ERR_INJ_EN
        // Error injection at bit 3, then clean
        do_reset;
        ifa.cod_ready   = 1;
        ifa.err_inj     = 1;
        ifa.err_inj_pos = 3'd3;
        ifa.req0_valid  = 1;
        ifa.req0_data   = 4'b1011;
        tick;
        ifa.req0_valid  = 0;
        tick;
        chk("t6_inj_data", ifa.cod_data, 8'h5D);
        tick;
        chk("t6_inj_cnt0", ifa.cnt0, 1);
        ifa.err_inj     = 0;
        ifa.req0_valid  = 1;
        tick;
        ifa.req0_valid  = 0;
        tick;
        chk("t6_clean_data", ifa.cod_data, 8'h55);
        tick;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
